// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and sizes for the Simon32/64 serial front end.
package simon_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_PT, FIRE, WAIT, DRAIN} seq_state_t;

  localparam int SIMON_KEY_W = 64;
  localparam int SIMON_BLK_W = 32;
  localparam int SIMON_LAT   = 32;

endpackage

// File: rtl/simon_ser_shift.sv
// rtl/simon_ser_shift.sv - load/shift register with a beat counter.
// Beats enter at the top and move down, so the first beat ends up in bits [BUS_W-1:0].
module simon_ser_shift #(
  parameter int W     = 32,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift,
  input  logic [BUS_W-1:0] shift_in,
  output logic [W-1:0]     data,
  output logic             at_last
);

  localparam int BEATS = W / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [W-1:0]       data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W+BUS_W-1:0] shifted;

  assign shifted = {shift_in, data_q};
  assign at_last = (cnt_q == CNT_W'(BEATS - 1));
  assign data    = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (shift) begin
      data_d = shifted[W+BUS_W-1:BUS_W];
      cnt_d  = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/simon_io_seq.sv
// rtl/simon_io_seq.sv - byte-serial loader, start sequencer and ciphertext drain for simon_pipeline.
module simon_io_seq
  import simon_pkg::*;
#(
  parameter int BUS_W   = 8,
  parameter int KEY_W   = SIMON_KEY_W,
  parameter int BLK_W   = SIMON_BLK_W,
  parameter int LATENCY = SIMON_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             new_key,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             key_loaded,
  output logic [KEY_W-1:0] core_keytext,
  output logic [BLK_W-1:0] core_plaintext,
  output logic             core_start,
  input  logic [BLK_W-1:0] core_ciphertext
);

  seq_state_t  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        key_loaded_q, key_loaded_d;
  logic        key_shift, pt_shift, ct_load, ct_shift;
  logic        key_last, pt_last, ct_last;
  logic        in_fire;
  logic [BLK_W-1:0] ct_data;
  logic        ct_hi_unused;

  assign in_ready   = (state_q == IDLE) || (state_q == LOAD_KEY) || (state_q == LOAD_PT);
  assign in_fire    = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign core_start = (state_q == FIRE);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = ct_data[BUS_W-1:0];
  assign key_loaded = key_loaded_q;
  assign ct_hi_unused = ^ct_data;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    key_loaded_d = key_loaded_q;
    key_shift    = 1'b0;
    pt_shift     = 1'b0;
    ct_load      = 1'b0;
    ct_shift     = 1'b0;
    case (state_q)
      IDLE: if (in_fire) begin
        // A missing key forces the key phase even when the host asked for reuse.
        if (new_key || !key_loaded_q) begin
          key_shift    = 1'b1;
          key_loaded_d = key_last;
          state_d      = key_last ? LOAD_PT : LOAD_KEY;
        end else begin
          pt_shift = 1'b1;
          state_d  = pt_last ? FIRE : LOAD_PT;
        end
      end
      LOAD_KEY: if (in_fire) begin
        key_shift = 1'b1;
        if (key_last) begin
          key_loaded_d = 1'b1;
          state_d      = LOAD_PT;
        end
      end
      LOAD_PT: if (in_fire) begin
        pt_shift = 1'b1;
        if (pt_last) state_d = FIRE;
      end
      FIRE: begin
        wait_cnt_d = 8'(LATENCY - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 8'd0) begin
          ct_load = 1'b1;
          state_d = DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      DRAIN: if (out_ready) begin
        ct_shift = 1'b1;
        if (ct_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  simon_ser_shift #(.W(KEY_W), .BUS_W(BUS_W)) u_key (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(key_shift), .shift_in(in_data), .data(core_keytext), .at_last(key_last)
  );

  simon_ser_shift #(.W(BLK_W), .BUS_W(BUS_W)) u_pt (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift(pt_shift), .shift_in(in_data), .data(core_plaintext), .at_last(pt_last)
  );

  simon_ser_shift #(.W(BLK_W), .BUS_W(BUS_W)) u_ct (
    .clk(clk), .rst(rst), .load(ct_load), .load_data(core_ciphertext),
    .shift(ct_shift), .shift_in('0), .data(ct_data), .at_last(ct_last)
  );

endmodule

// File: tb/tb_simon_io_seq.sv
// tb/tb_simon_io_seq.sv - directed bench: two sequencers (LATENCY 32 and 1) each with a behavioural core stub.
module tb_simon_io_seq;

  localparam logic [63:0] KEY = 64'h1918111009080100;
  localparam logic [31:0] PT  = 32'h65656877;
  localparam logic [31:0] CT  = 32'hc69be9bb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        new_key;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  out_data [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        busy [2];
  logic        key_loaded [2];
  logic [63:0] core_keytext [2];
  logic [31:0] core_plaintext [2];
  logic        core_start [2];
  logic [31:0] core_ciphertext [2];
  int          lat_cnt [2] = '{0, 0};
  int          acc [2] = '{0, 0};
  int          n_total = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  simon_io_seq #(.LATENCY(32)) u_dut0 (
    .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .new_key(new_key), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .key_loaded(key_loaded[0]), .core_keytext(core_keytext[0]),
    .core_plaintext(core_plaintext[0]), .core_start(core_start[0]), .core_ciphertext(core_ciphertext[0])
  );

  simon_io_seq #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .new_key(new_key), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .key_loaded(key_loaded[1]), .core_keytext(core_keytext[1]),
    .core_plaintext(core_plaintext[1]), .core_start(core_start[1]), .core_ciphertext(core_ciphertext[1])
  );

  // Core stub: the ciphertext is only correct during the one cycle the latency says it should be.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (core_start[d]) lat_cnt[d] <= 1;
      else if (lat_cnt[d] != 0 && lat_cnt[d] < 1000) lat_cnt[d] <= lat_cnt[d] + 1;
      if (in_valid[d] && in_ready[d]) acc[d] <= acc[d] + 1;
    end
  end

  assign core_ciphertext[0] = (lat_cnt[0] == 32 && core_keytext[0] == KEY && core_plaintext[0] == PT)
                              ? CT : 32'hdeadbeef;
  assign core_ciphertext[1] = (lat_cnt[1] == 1 && core_keytext[1] == KEY && core_plaintext[1] == PT)
                              ? CT : 32'hdeadbeef;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic nk);
    int t;
    in_data = b;
    new_key = nk;
    in_valid[d] = 1'b1;
    t = 0;
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic fire_check(input int d, input int lat);
    int n;
    check("core_start_high", 64'(core_start[d]), 64'd1);
    @(negedge clk);
    check("core_start_one_cycle", 64'(core_start[d]), 64'd0);
    n = 1;
    while (!out_valid[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ct_latency", 64'(n), 64'(lat + 1));
  endtask

  task automatic recv(input int d, input logic [31:0] exp, input int stall_beat);
    int t;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!out_valid[d] && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (i == stall_beat) begin
        repeat (5) begin
          check("bp_valid", 64'(out_valid[d]), 64'd1);
          check("bp_data", 64'(out_data[d]), 64'(exp[8*i +: 8]));
          check("bp_busy", 64'(busy[d]), 64'd1);
          @(negedge clk);
        end
      end
      check($sformatf("ct_beat%0d", i), 64'(out_data[d]), 64'(exp[8*i +: 8]));
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1 out_ready[d] = 1'b0;
      @(negedge clk);
    end
    check("drain_done_valid", 64'(out_valid[d]), 64'd0);
    check("drain_done_busy", 64'(busy[d]), 64'd0);
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    in_data = 8'h00;
    new_key = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_key_loaded", 64'(key_loaded[0]), 64'd0);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_keytext", core_keytext[0], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a key load.
    for (int i = 0; i < 3; i++) send(0, KEY[8*i +: 8], 1'b1);
    check("midload_busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    check("midrst_key_loaded", 64'(key_loaded[0]), 64'd0);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_core_start", 64'(core_start[0]), 64'd0);
    check("midrst_keytext", core_keytext[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No key held: new_key=0 still consumes 8 key beats then 4 plaintext beats.
    a0 = acc[0];
    for (int i = 0; i < 8; i++) send(0, KEY[8*i +: 8], 1'b0);
    check("nokey_key_loaded", 64'(key_loaded[0]), 64'd1);
    check("nokey_no_start", 64'(core_start[0]), 64'd0);
    for (int i = 0; i < 4; i++) send(0, PT[8*i +: 8], 1'b0);
    check("nokey_beats", 64'(acc[0] - a0), 64'd12);
    check("nokey_keytext", core_keytext[0], KEY);
    check("nokey_pt", 64'(core_plaintext[0]), 64'(PT));
    fire_check(0, 32);
    recv(0, CT, -1);

    // Full job with new_key=1 and backpressure on beat 2.
    a0 = acc[0];
    for (int i = 0; i < 8; i++) send(0, KEY[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send(0, PT[8*i +: 8], 1'b1);
    check("full_beats", 64'(acc[0] - a0), 64'd12);
    fire_check(0, 32);
    recv(0, CT, 2);

    // Key reuse, with in_valid held high through FIRE/WAIT/DRAIN.
    a0 = acc[0];
    for (int i = 0; i < 4; i++) send(0, PT[8*i +: 8], 1'b0);
    in_data = 8'h5a;
    in_valid[0] = 1'b1;
    check("reuse_beats", 64'(acc[0] - a0), 64'd4);
    check("reuse_keytext", core_keytext[0], KEY);
    fire_check(0, 32);
    check("ignore_in_ready", 64'(in_ready[0]), 64'd0);
    recv(0, CT, -1);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("ignore_beats", 64'(acc[0] - a0), 64'd4);
    check("ignore_keytext", core_keytext[0], KEY);
    check("ignore_pt", 64'(core_plaintext[0]), 64'(PT));
    check("ignore_idle", 64'(in_ready[0]), 64'd1);

    // LATENCY=1 instance: capture on the edge right after FIRE.
    for (int i = 0; i < 8; i++) send(1, KEY[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send(1, PT[8*i +: 8], 1'b1);
    check("lat1_beats", 64'(acc[1]), 64'd12);
    fire_check(1, 1);
    recv(1, CT, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
